// File: rtl/systolic_mul_4x4.sv
// systolic_mul_4x4
//   4x4 output-stationary systolic array computing C = A x B on unsigned
//   DATA_WIDTH-bit elements. Rows of A enter skewed from the left edge and
//   columns of B enter skewed from the top edge. PE(r,c) accumulates C[r][c]
//   and forwards its A operand right and its B operand down, one cycle per hop.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous reset, active HIGH despite the name
//   left_i_0/4/8/12  A row streams 0..3 (row r skewed by r cycles)
//   up_i_0..3        B column streams 0..3 (column c skewed by c cycles)
//   done             high once all 16 accumulators are final; held until reset
//   res_o            packed results, C[r][c] at [(4r+c)*DATA_WIDTH +: DATA_WIDTH]

module systolic_mul_4x4 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_WIDTH-1:0]    left_i_0,
  input  logic [DATA_WIDTH-1:0]    left_i_4,
  input  logic [DATA_WIDTH-1:0]    left_i_8,
  input  logic [DATA_WIDTH-1:0]    left_i_12,
  input  logic [DATA_WIDTH-1:0]    up_i_0,
  input  logic [DATA_WIDTH-1:0]    up_i_1,
  input  logic [DATA_WIDTH-1:0]    up_i_2,
  input  logic [DATA_WIDTH-1:0]    up_i_3,
  output logic                     done,
  output logic [16*DATA_WIDTH-1:0] res_o
);

  // The last operand pair (A[3][3], B[3][3]) meets in PE(3,3) at cycle 3+3+3.
  localparam logic [3:0] LAST_CYCLE = 4'd9;

  logic [DATA_WIDTH-1:0] w_left [4];
  logic [DATA_WIDTH-1:0] w_up   [4];
  logic [DATA_WIDTH-1:0] w_a_in [4][4];
  logic [DATA_WIDTH-1:0] w_b_in [4][4];

  logic [DATA_WIDTH-1:0] r_acc  [4][4];
  logic [DATA_WIDTH-1:0] r_a    [4][4];
  logic [DATA_WIDTH-1:0] r_b    [4][4];

  logic [3:0]            r_cnt;
  logic                  r_done;

  assign w_left[0] = left_i_0;
  assign w_left[1] = left_i_4;
  assign w_left[2] = left_i_8;
  assign w_left[3] = left_i_12;

  assign w_up[0] = up_i_0;
  assign w_up[1] = up_i_1;
  assign w_up[2] = up_i_2;
  assign w_up[3] = up_i_3;

  // Edge counter: counts rising edges after reset, saturating. done is
  // registered on the edge of cycle 9, i.e. the same edge that performs the
  // final accumulate in PE(3,3), so it is visible right after that edge.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      if (r_cnt != 4'hF) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_cnt == LAST_CYCLE) begin
        r_done <= 1'b1;
      end
    end
  end

  assign done = r_done;

  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
      logic [DATA_WIDTH-1:0] w_prod;

      if (gc == 0) begin : g_a_edge
        assign w_a_in[gr][gc] = w_left[gr];
      end else begin : g_a_inner
        assign w_a_in[gr][gc] = r_a[gr][gc-1];
      end

      if (gr == 0) begin : g_b_edge
        assign w_b_in[gr][gc] = w_up[gc];
      end else begin : g_b_inner
        assign w_b_in[gr][gc] = r_b[gr-1][gc];
      end

      // Product is taken in DATA_WIDTH context, so it keeps only the low bits;
      // the accumulator likewise wraps modulo 2^DATA_WIDTH.
      assign w_prod = w_a_in[gr][gc] * w_b_in[gr][gc];

      always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
          r_acc[gr][gc] <= '0;
          r_a[gr][gc]   <= '0;
          r_b[gr][gc]   <= '0;
        end else if (!r_done) begin
          r_acc[gr][gc] <= r_acc[gr][gc] + w_prod;
          r_a[gr][gc]   <= w_a_in[gr][gc];
          r_b[gr][gc]   <= w_b_in[gr][gc];
        end
      end

      assign res_o[(4*gr+gc)*DATA_WIDTH +: DATA_WIDTH] = r_acc[gr][gc];
    end
  end

endmodule

// File: tb/tb_systolic_mul_4x4.sv
module tb_systolic_mul_4x4;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic [DW-1:0] left_i_0 = '0, left_i_4 = '0, left_i_8 = '0, left_i_12 = '0;
  logic [DW-1:0] up_i_0 = '0, up_i_1 = '0, up_i_2 = '0, up_i_3 = '0;
  logic          done;
  logic [16*DW-1:0] res_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mat_a [4][4];
  logic [DW-1:0] mat_b [4][4];
  logic [DW-1:0] c_exp [4][4];

  systolic_mul_4x4 #(.DATA_WIDTH(DW)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .left_i_0 (left_i_0),
    .left_i_4 (left_i_4),
    .left_i_8 (left_i_8),
    .left_i_12(left_i_12),
    .up_i_0   (up_i_0),
    .up_i_1   (up_i_1),
    .up_i_2   (up_i_2),
    .up_i_3   (up_i_3),
    .done     (done),
    .res_o    (res_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] res_at(input int r, input int c);
    return res_o[(4*r+c)*DW +: DW];
  endfunction

  // Reference: plain matrix product, done in 64-bit and reduced modulo 2^32.
  task automatic model();
    longint unsigned sum;
    longint unsigned prod;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sum = 0;
        for (int k = 0; k < 4; k++) begin
          prod = (longint'(mat_a[r][k]) * longint'(mat_b[k][c])) & 64'hFFFF_FFFF;
          sum  = (sum + prod) & 64'hFFFF_FFFF;
        end
        c_exp[r][c] = sum[DW-1:0];
      end
    end
  endtask

  task automatic drive_zero();
    left_i_0 = '0; left_i_4 = '0; left_i_8 = '0; left_i_12 = '0;
    up_i_0 = '0; up_i_1 = '0; up_i_2 = '0; up_i_3 = '0;
  endtask

  task automatic drive_random();
    left_i_0 = $urandom; left_i_4 = $urandom; left_i_8 = $urandom; left_i_12 = $urandom;
    up_i_0 = $urandom; up_i_1 = $urandom; up_i_2 = $urandom; up_i_3 = $urandom;
  endtask

  // Row r carries A[r][n-r] at cycle n; column c carries B[n-c][c].
  task automatic drive_cycle(input int n);
    logic [DW-1:0] lv [4];
    logic [DW-1:0] uv [4];
    for (int i = 0; i < 4; i++) begin
      lv[i] = (n - i >= 0 && n - i < 4) ? mat_a[i][n-i] : '0;
      uv[i] = (n - i >= 0 && n - i < 4) ? mat_b[n-i][i] : '0;
    end
    left_i_0 = lv[0]; left_i_4 = lv[1]; left_i_8 = lv[2]; left_i_12 = lv[3];
    up_i_0 = uv[0]; up_i_1 = uv[1]; up_i_2 = uv[2]; up_i_3 = uv[3];
  endtask

  task automatic hold_reset();
    drive_zero();
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  // Releases reset and streams one multiply. abort_at >= 0 asserts reset
  // between edges right after that cycle and checks the immediate clear.
  task automatic run_mul(input string tag, input int abort_at);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      if (n == 0) rst_ni = 1'b0;
      drive_cycle(n);
      @(posedge clk_i);
      #1;
      chk({tag, "_done_c", $sformatf("%0d", n)}, {31'd0, done}, (n >= 9) ? 32'd1 : 32'd0);
      if (n == abort_at) begin
        #2;
        rst_ni = 1'b1;
        #1;
        chk({tag, "_abort_done"}, {31'd0, done}, 32'd0);
        for (int i = 0; i < 16; i++)
          chk({tag, "_abort_res"}, res_at(i / 4, i % 4), '0);
        drive_zero();
        return;
      end
    end
    @(negedge clk_i);
    drive_zero();
  endtask

  task automatic check_results(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_c%0d%0d", tag, r, c), res_at(r, c), c_exp[r][c]);
  endtask

  task automatic load_basic();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        mat_a[r][k] = DW'(4 * r + k + 1);
        mat_b[r][k] = DW'(k + 1);
      end
  endtask

  initial begin
    // Reset state
    hold_reset();
    chk("reset_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 16; i++) chk("reset_res", res_at(i / 4, i % 4), '0);

    // Basic multiply with hand-computed anchors
    load_basic();
    model();
    run_mul("basic", -1);
    check_results("basic");
    chk("basic_c00", res_at(0, 0), 32'd10);
    chk("basic_c03", res_at(0, 3), 32'd40);
    chk("basic_c11", res_at(1, 1), 32'd52);
    chk("basic_c22", res_at(2, 2), 32'd126);
    chk("basic_c30", res_at(3, 0), 32'd58);
    chk("basic_c33", res_at(3, 3), 32'd232);

    // Freeze after done while inputs toggle randomly
    for (int j = 0; j < 5; j++) begin
      @(negedge clk_i);
      drive_random();
      @(posedge clk_i);
      #1;
      chk("freeze_done", {31'd0, done}, 32'd1);
      check_results("freeze");
    end
    drive_zero();

    // Identity
    hold_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = DW'($urandom_range(16, 1));
        mat_b[r][c] = (r == c) ? 32'd1 : 32'd0;
      end
    model();
    run_mul("ident", -1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk("ident_eq_a", res_at(r, c), mat_a[r][c]);

    // Wrap-around of a truncated product
    hold_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = '0;
        mat_b[r][c] = '0;
      end
    mat_a[0][0] = 32'h0001_0000;
    mat_b[0][0] = 32'h0001_0000;
    model();
    run_mul("wrap", -1);
    check_results("wrap");

    // Zero inputs
    hold_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r][c] = '0;
        mat_b[r][c] = '0;
      end
    model();
    run_mul("zero", -1);
    check_results("zero");

    // Randomized full-range matrices
    for (int t = 0; t < 4; t++) begin
      hold_reset();
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          mat_a[r][c] = $urandom;
          mat_b[r][c] = (t < 2) ? DW'($urandom_range(255)) : $urandom;
        end
      model();
      run_mul("rand", -1);
      check_results("rand");
    end

    // Reset mid-operation, then rerun basic
    hold_reset();
    load_basic();
    model();
    run_mul("abort", 5);
    repeat (2) @(posedge clk_i);
    #1;
    run_mul("rerun", -1);
    check_results("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_mul_4x4.md
Name: systolic_mul_4x4

Overview:
- 4x4 output-stationary systolic array that computes C = A x B for 4x4 matrices of unsigned DATA_WIDTH-bit elements.
- Rows of A enter skewed from the left edge; columns of B enter skewed from the top edge.
- Each of the 16 processing elements (PEs) accumulates one element of C and forwards its operands right and down.
- Sits as the compute core of the matrix-multiply datapath and raises done when all 16 results are final.

Parameters:
- DATA_WIDTH, 32, width of every operand, product, accumulator and result element.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous, active-high reset. The name follows codebase convention; the polarity is high.
- left_i_0  input  DATA_WIDTH  row 0 stream of A; element A[0][k] is presented at cycle k.
- left_i_4  input  DATA_WIDTH  row 1 stream of A; A[1][k] at cycle k+1, 0 otherwise.
- left_i_8  input  DATA_WIDTH  row 2 stream of A; A[2][k] at cycle k+2.
- left_i_12  input  DATA_WIDTH  row 3 stream of A; A[3][k] at cycle k+3.
- up_i_0  input  DATA_WIDTH  column 0 stream of B; B[k][0] at cycle k.
- up_i_1  input  DATA_WIDTH  column 1 stream of B; B[k][1] at cycle k+1.
- up_i_2  input  DATA_WIDTH  column 2 stream of B; B[k][2] at cycle k+2.
- up_i_3  input  DATA_WIDTH  column 3 stream of B; B[k][3] at cycle k+3.
- done  output  1  high once all results are final.
- res_o  output  16*DATA_WIDTH  results; res_o[(4r+c)*DATA_WIDTH +: DATA_WIDTH] = C[r][c].

Behaviour:
- Cycle numbering: cycle 0 is the first rising edge after rst_ni deasserts.
- PE(r,c) state:
  - acc: accumulator.
  - a_reg: A operand, forwarded right.
  - b_reg: B operand, forwarded down.
- PE(r,c) operand sources:
  - a_in is left_i_(4r) when c=0, else a_reg of PE(r,c-1).
  - b_in is up_i_c when r=0, else b_reg of PE(r-1,c).
- Each rising edge while not done:
  - acc <= acc + a_in*b_in.
  - a_reg <= a_in.
  - b_reg <= b_in.
- Each hop between PEs costs exactly one cycle. A[r][k] and B[k][c] therefore meet in PE(r,c) at cycle r+c+k.
- Arithmetic:
  - Unsigned.
  - The product is truncated to its low DATA_WIDTH bits.
  - The accumulator wraps modulo 2^DATA_WIDTH; there is no overflow flag.
- Cycle counter:
  - 4-bit, counts rising edges after reset and saturates.
  - The last operand pair reaches PE(3,3) at cycle 9.
  - done goes high (registered) at the edge of cycle 9, visible after it, and stays high until reset.
- Once done=1, all acc, a_reg and b_reg freeze. res_o holds C and input changes are ignored.
- res_o is driven continuously from the accumulators. Values before done are partial sums and are not valid.
- Reset, asynchronous at assertion, forces:
  - all acc, a_reg and b_reg to 0;
  - the counter to 0;
  - done=0 and res_o=0.
- Reset asserted mid-operation aborts the computation immediately. A new multiply starts at cycle 0 after release.
- Inputs outside their valid skew window must be driven 0. Nonzero values there corrupt results; no checking is done.
- No handshake: one multiply per reset. Back-to-back operation requires a reset pulse between matrices.

Test Plan:
- Basic multiply:
  - Stimulus: A rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; B[k][c]=c+1; skewed per port rules.
  - Required: after done, C[0][0]=10, C[0][3]=40, C[1][1]=52, C[2][2]=126, C[3][0]=58, C[3][3]=232.
- done timing:
  - Same stimulus.
  - Required: done=0 through the edge of cycle 8; done=1 after the edge of cycle 9; res_o unchanged for 5 further cycles while random inputs are applied.
- Identity:
  - Stimulus: A = arbitrary values 1..16, B = I.
  - Required: C equals A element for element.
- Wrap-around:
  - Stimulus: A[0][0]=B[0][0]=0x10000, all other entries 0.
  - Required: C[0][0]=0 (truncated) and every other C element 0.
- Reset mid-operation:
  - Stimulus: assert rst_ni high at cycle 5, asynchronously between edges.
  - Required: res_o=0 and done=0 immediately. After release, rerunning the basic stimulus gives the basic results.
- Zero inputs:
  - Stimulus: all inputs 0.
  - Required: done at cycle 9 and res_o all zero.
